// File: rtl/alu_mul_sequencer_pkg.sv
// alu_mul_sequencer_pkg: ALU opcode list and multiply sequencer state encoding shared with the control unit
package alu_mul_sequencer_pkg;
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_ADC  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SBC  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_ASR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ROR  = 5'd12;
  localparam logic [4:0] OP_INC  = 5'd13;
  localparam logic [4:0] OP_DEC  = 5'd14;
  localparam logic [4:0] OP_AREM = 5'd15;
  typedef enum logic [1:0] {IDLE, ITER, FLAGS} state_t;
  // A clear multiplier bit still drives a defined, side-effect-free opcode
  function automatic logic [4:0] step_op(input logic mp_bit);
    return mp_bit ? OP_ADD : OP_AREM;
  endfunction
endpackage

// File: rtl/alu_mul_sequencer_if.sv
// alu_mul_sequencer_if: multiply launch/result bundle between control unit (master) and sequencer (slave)
interface alu_mul_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             flag_n;
  logic             flag_z;
  logic             flag_ovf;
  modport master (output start, mcand, mplr, input busy, done, product, flag_n, flag_z, flag_ovf);
  modport slave  (input start, mcand, mplr, output busy, done, product, flag_n, flag_z, flag_ovf);
endinterface

// File: rtl/alu_mul_sequencer_port_mux.sv
// alu_mul_sequencer_port_mux: selects datapath or sequencer drive of the shared ALU inputs
module alu_mul_sequencer_port_mux #(parameter int WIDTH = 32) (
  input  logic             i_sel_seq,
  input  logic [WIDTH-1:0] i_seq_a,
  input  logic [WIDTH-1:0] i_seq_b,
  input  logic [4:0]       i_seq_op,
  input  logic             i_seq_cin,
  input  logic [WIDTH-1:0] i_dp_a,
  input  logic [WIDTH-1:0] i_dp_b,
  input  logic [4:0]       i_dp_op,
  input  logic             i_dp_cin,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [4:0]       o_alu_op,
  output logic             o_alu_cin
);
  always_comb begin
    o_alu_a   = i_sel_seq ? i_seq_a   : i_dp_a;
    o_alu_b   = i_sel_seq ? i_seq_b   : i_dp_b;
    o_alu_op  = i_sel_seq ? i_seq_op  : i_dp_op;
    o_alu_cin = i_sel_seq ? i_seq_cin : i_dp_cin;
  end
endmodule

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add 32-bit unsigned multiply using the shared ALU; transparent when idle
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic              clk,
  input  logic              reset_n,
  alu_mul_sequencer_if.slave bus,
  input  logic [WIDTH-1:0]  i_dp_a,
  input  logic [WIDTH-1:0]  i_dp_b,
  input  logic [4:0]        i_dp_op,
  input  logic              i_dp_cin,
  output logic [WIDTH-1:0]  o_alu_a,
  output logic [WIDTH-1:0]  o_alu_b,
  output logic [4:0]        o_alu_op,
  output logic              o_alu_cin,
  input  logic [WIDTH-1:0]  i_alu_result,
  input  logic              i_alu_c,
  input  logic              i_alu_n,
  input  logic              i_alu_z
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_mc;
  logic [WIDTH-1:0] r_mp;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_product;
  logic [CW-1:0]    r_cnt;
  logic             r_lost;
  logic             r_ovf;
  logic             r_done;
  logic             r_n;
  logic             r_z;
  logic             r_flag_ovf;
  logic             w_busy;
  logic             w_last;
  logic [4:0]       w_seq_op;
  always_comb begin
    w_busy   = r_state != IDLE;
    w_last   = (r_mp >> 1) == '0 || r_cnt == CW'(WIDTH - 1);
    w_seq_op = r_state == ITER ? step_op(r_mp[0]) : OP_AREM;
  end
  // A bit shifted out of mc only matters if a later multiplier bit adds it in
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_mc       <= '0;
      r_mp       <= '0;
      r_acc      <= '0;
      r_product  <= '0;
      r_cnt      <= '0;
      r_lost     <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_n        <= 1'b0;
      r_z        <= 1'b0;
      r_flag_ovf <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_mc    <= bus.mcand;
          r_mp    <= bus.mplr;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_lost  <= 1'b0;
          r_ovf   <= 1'b0;
          r_state <= ITER;
        end
        ITER: begin
          if (r_mp[0]) begin
            r_acc <= i_alu_result;
            r_ovf <= r_ovf | i_alu_c | r_lost;
          end
          r_lost <= r_lost | r_mc[WIDTH-1];
          r_mc   <= r_mc << 1;
          r_mp   <= r_mp >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_state <= FLAGS;
        end
        FLAGS: begin
          r_product  <= r_acc;
          r_n        <= i_alu_n;
          r_z        <= i_alu_z;
          r_flag_ovf <= r_ovf;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.busy     = w_busy;
  assign bus.done     = r_done;
  assign bus.product  = r_product;
  assign bus.flag_n   = r_n;
  assign bus.flag_z   = r_z;
  assign bus.flag_ovf = r_flag_ovf;
  alu_mul_sequencer_port_mux #(.WIDTH(WIDTH)) u_port_mux (
    .i_sel_seq (w_busy),
    .i_seq_a   (r_acc),
    .i_seq_b   (r_mc),
    .i_seq_op  (w_seq_op),
    .i_seq_cin (1'b0),
    .i_dp_a    (i_dp_a),
    .i_dp_b    (i_dp_b),
    .i_dp_op   (i_dp_op),
    .i_dp_cin  (i_dp_cin),
    .o_alu_a   (o_alu_a),
    .o_alu_b   (o_alu_b),
    .o_alu_op  (o_alu_op),
    .o_alu_cin (o_alu_cin)
  );
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: scoreboard bench with a behavioural ALU; expected products from a 64-bit multiply
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;
  localparam int W = 32;
  typedef struct {
    logic [W-1:0] p;
    logic         n;
    logic         z;
    logic         ovf;
    int           iters;
    int           t0;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  alu_mul_sequencer_if #(.WIDTH(W)) bus ();
  logic [W-1:0] dp_a, dp_b, alu_a, alu_b, alu_result;
  logic [4:0]   dp_op, alu_op;
  logic         dp_cin, alu_cin, alu_c, alu_n, alu_z;
  logic [W:0]   w_sum;
  alu_mul_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .i_dp_a       (dp_a),
    .i_dp_b       (dp_b),
    .i_dp_op      (dp_op),
    .i_dp_cin     (dp_cin),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_alu_cin    (alu_cin),
    .i_alu_result (alu_result),
    .i_alu_c      (alu_c),
    .i_alu_n      (alu_n),
    .i_alu_z      (alu_z)
  );
  // Behavioural ALU: ADD, SUB, and pass-A for AREM and everything else
  always_comb begin
    w_sum = {1'b0, alu_a};
    if (alu_op == OP_ADD) w_sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
    else if (alu_op == OP_SUB) w_sum = {1'b0, alu_a} - {1'b0, alu_b};
    alu_result = w_sum[W-1:0];
    alu_c      = w_sum[W];
    alu_n      = w_sum[W-1];
    alu_z      = w_sum[W-1:0] == '0;
  end
  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t sb[$];
  exp_t e;
  logic [W-1:0] add_b[$];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (bus.busy && alu_op == OP_ADD) add_b.push_back(alu_b);
    if (bus.done) begin
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        check("product", bus.product, e.p);
        check("flag_n", bus.flag_n, e.n);
        check("flag_z", bus.flag_z, e.z);
        check("flag_ovf", bus.flag_ovf, e.ovf);
        // count includes the edge that samples done
        check("latency", cyc - e.t0 + 1, e.iters + 2);
      end
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    logic [63:0] p;
    int hi;
    p = {32'b0, a} * {32'b0, b};
    hi = 0;
    for (int i = 0; i < W; i++) if (b[i]) hi = i + 1;
    x.p = p[W-1:0];
    x.n = p[W-1];
    x.z = p[W-1:0] == '0;
    x.ovf = p[63:W] != '0;
    x.iters = hi == 0 ? 1 : hi;
    x.t0 = cyc + 1;
    sb.push_back(x);
    bus.start = 1'b1;
    bus.mcand = a;
    bus.mplr = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("timeout", 0, 1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.mcand = '0;
    bus.mplr = '0;
    dp_a = 32'hA5A5_5A5A;
    dp_b = 32'h0F0F_F0F0;
    dp_op = OP_SUB;
    dp_cin = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_product", bus.product, 0);
    check("rst_flags", {bus.flag_n, bus.flag_z, bus.flag_ovf}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    add_b.delete();
    issue(7, 6);
    wait_done();
    check("add_count", add_b.size(), 2);
    check("add_b0", add_b.size() > 0 ? add_b[0] : 32'h0, 14);
    check("add_b1", add_b.size() > 1 ? add_b[1] : 32'h0, 28);
    issue(32'h1234, 0);
    check("busy_after_done_start", bus.busy, 1);
    wait_done();
    @(negedge clk);
    issue(32'hFFFF_FFFF, 2);
    wait_done();
    @(negedge clk);
    issue(32'h0001_0000, 32'h0001_0000);
    wait_done();
    @(negedge clk);
    issue(3, 5);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mcand = 9;
    bus.mplr = 32'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      issue($urandom, $urandom_range(1, 1 << (4 * k + 3)));
      wait_done();
      @(negedge clk);
    end
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_product", bus.product, 0);
    check("midrst_flags", {bus.flag_n, bus.flag_z, bus.flag_ovf}, 0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    dp_a = 5;
    dp_b = 3;
    dp_op = 5'd2;
    dp_cin = 1'b0;
    #1;
    check("pass_a", alu_a, 5);
    check("pass_b", alu_b, 3);
    check("pass_op", alu_op, 2);
    check("pass_cin", alu_cin, 0);
    check("pass_result", alu_result, 2);
    dp_cin = 1'b1;
    #1;
    check("pass_cin1", alu_cin, 1);
    @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle controller that owns the shared ALU while it computes a 32-bit unsigned multiply (low word of the product) by shift-and-add. Each accumulation is an ALU ADD. Final N/Z come from one ALU AREM pass. When idle, the block is transparent: the normal datapath's ALU operands and opcode pass straight through. Sits between the datapath's operand/opcode muxes and the ALU inputs; the control unit launches it for MUL instructions.

Parameters:
WIDTH, 32, operand/result width; must equal the ALU width.
OP_ADD, 5'd0, ALU opcode for A+B (C = carry out).
OP_AREM, 5'd15, ALU opcode that passes A unmodified (N/Z valid).

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  launch a multiply; sampled only in IDLE.
mcand  in  WIDTH  multiplicand, captured on an accepted start.
mplr  in  WIDTH  multiplier, captured on an accepted start.
busy  out  1  high in any state other than IDLE; also serves as the datapath stall.
done  out  1  one-cycle pulse; product and flags valid.
product  out  WIDTH  low WIDTH bits of mcand*mplr; held until the next accepted start.
flag_n, flag_z  out  1  sign and zero of product from the ALU; held with product.
flag_ovf  out  1  true product is >= 2^WIDTH; held with product.
dp_a, dp_b  in  WIDTH  datapath ALU operands (passthrough).
dp_op  in  5  datapath ALU opcode.
dp_cin  in  1  datapath carry-in.
alu_a, alu_b  out  WIDTH  ALU operand drive.
alu_op  out  5  ALU opcode drive.
alu_cin  out  1  ALU carry-in drive.
alu_result  in  WIDTH  ALU result.
alu_c, alu_n, alu_z  in  1  ALU condition codes (alu_v unused).

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, product=0, flag_n/z/ovf=0; internal acc, shift registers, count and lost flag cleared. No partial result is ever reported.
- IDLE:
  - ALU outputs combinationally equal dp_a/dp_b/dp_op/dp_cin.
  - On start=1: capture mc=mcand, mp=mplr; set acc=0, count=0, lost=0, ovf_i=0; go to ITER.
- ITER, one iteration per cycle; alu_cin=0:
  - If mp[0]=1: drive alu_a=acc, alu_b=mc, alu_op=OP_ADD; register acc<=alu_result; ovf_i |= alu_c | lost.
  - If mp[0]=0: drive alu_op=OP_AREM, alu_a=acc, alu_b=mc; acc is unchanged.
  - Every iteration: lost |= mc[WIDTH-1]; mc<=mc<<1; mp<=mp>>1; count++.
  - Exit to FLAGS when (mp>>1)==0 or count==WIDTH-1.
  - Iterations = max(1, index of highest set bit of mplr + 1).
- FLAGS (1 cycle): drive alu_a=acc, alu_op=OP_AREM; register product<=acc, flag_n<=alu_n, flag_z<=alu_z, flag_ovf<=ovf_i; go to IDLE with done<=1.
- done is high exactly one cycle, the first IDLE cycle. A start in that cycle is accepted.
- Latency: start at edge t → done high at cycle t + iterations + 2.
- start while busy: ignored, with no queueing.
- Overflow rule: a lost multiplicand bit only counts if a later multiplier bit is set; any ADD carry counts. This is exact for unsigned products.
- ALU is combinational: operands and opcode must be stable for the full cycle. No X may be driven on the ALU ports in any state.

Decomposition:
- alu_pkg: opcode constants (OP_ADD, OP_AREM and the rest of the ALU opcode list) and state encoding (IDLE, ITER, FLAGS); shared with the control unit.
- One sub-module is natural: alu_port_mux, which selects datapath vs sequencer drive of alu_a/alu_b/alu_op/alu_cin on busy.
- The FSM, counters and shift registers stay in alu_mul_sequencer.

Test Plan:
- mcand=7, mplr=6 → 3 ITER cycles; done at start+5; product=42, n=0, z=0, ovf=0. ALU sees ADD with B=14, then ADD with B=28.
- mcand=0x1234, mplr=0 → 1 ITER cycle; done at start+3; product=0, z=1, ovf=0.
- mcand=0xFFFFFFFF, mplr=2 → product=0xFFFFFFFE, n=1, ovf=1 (lost bit before the set multiplier bit).
- mcand=0x00010000, mplr=0x00010000 → product=0, z=1, ovf=1. Also 0xFFFFFFFF*0xFFFFFFFF → product=1, ovf=1, 32 iterations, done at start+34.
- start re-pulsed mid-op with new operands → ignored, original result reported; start in the done cycle → accepted, busy next cycle.
- reset_n low mid-ITER → immediate IDLE, all outputs 0, no done. In IDLE, dp_a=5, dp_b=3, dp_op=2 → ALU ports equal these same cycle; alu_result=2.
